seqdet_param: RTL and testbench

Parametrised serial pattern detector: samples one bit of `x` per qualified clock and reports when the most recent `PAT_W` samples equal a run-time-programmable pattern. Generalises the lab-series fixed-pattern detector with:
- programmable pattern width and value,
- an input-valid qualifier,
- selectable overlapping/non-overlapping detection,
- a saturating match counter.

It sits between a bit-serial source (switch/debouncer or shift-out stage) and the display/LED logic that consumes `z` and `match_cnt`.

---
 rtl/seqdet_pkg.sv | 13 +
 rtl/seqdet_param_if.sv | 29 ++
 rtl/seqdet_hist.sv | 41 ++++
 rtl/seqdet_param.sv | 76 +++++++
 tb/tb_seqdet_param.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seqdet_pkg;

    localparam int unsigned PAT_W_DEF   = 4;
    localparam logic [3:0]  PAT_RST_DEF = 4'b1010;
    localparam int unsigned CNT_W_DEF   = 8;

    // Width needed to count 0..pat_w valid history samples.
    function automatic int unsigned fill_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_param_if.sv
// Serial-bit, configuration and result signals of the pattern detector.
interface seqdet_param_if
    import seqdet_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic                        x;
    logic                        in_valid;
    logic                        cfg_load;
    logic [PAT_W-1:0]            pattern_in;
    logic                        overlap_in;
    logic                        cnt_clr;
    logic                        z;
    logic [CNT_W-1:0]            match_cnt;
    logic [fill_w(PAT_W)-1:0]    fill;

    modport master (
        output x, in_valid, cfg_load, pattern_in, overlap_in, cnt_clr,
        input  z, match_cnt, fill
    );

    modport slave (
        input  x, in_valid, cfg_load, pattern_in, overlap_in, cnt_clr,
        output z, match_cnt, fill
    );

endinterface

// File: rtl/seqdet_hist.sv
// Sample history shift register with a saturating count of valid samples.
module seqdet_hist
    import seqdet_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     shift,
    input  logic                     restart,
    input  logic                     x,
    output logic [PAT_W-1:0]         hist_n,
    output logic [fill_w(PAT_W)-1:0] fill_n,
    output logic [fill_w(PAT_W)-1:0] fill
);

    localparam int unsigned FW = fill_w(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill_q;

    // Newest sample enters at bit 0, so the MSB holds the oldest one.
    assign hist_n = {hist[PAT_W-2:0], x};
    assign fill_n = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
    assign fill   = fill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist   <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist   <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist   <= hist_n;
            fill_q <= restart ? '0 : fill_n;
        end
    end

endmodule

// File: rtl/seqdet_param.sv
// Programmable serial pattern detector with overlap control and saturating match counter.
module seqdet_param
    import seqdet_pkg::*;
#(
    parameter int unsigned      PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
    parameter int unsigned      CNT_W   = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    seqdet_param_if.slave bus
);

    localparam int unsigned      FW      = fill_w(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pat_reg;
    logic             overlap_reg;
    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill_n;
    logic [FW-1:0]    fill;
    logic             shift;
    logic             match;
    logic             z_q;
    logic [CNT_W-1:0] cnt_q;

    assign shift = bus.in_valid && !bus.cfg_load;
    // fill gates the compare so stale history never produces a match.
    assign match = shift && (fill_n == FW'(PAT_W)) && (hist_n == pat_reg);

    seqdet_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clr     (bus.cfg_load),
        .shift   (shift),
        .restart (match && !overlap_reg),
        .x       (bus.x),
        .hist_n  (hist_n),
        .fill_n  (fill_n),
        .fill    (fill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_reg     <= PAT_RST;
            overlap_reg <= 1'b1;
            z_q         <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (bus.cfg_load) begin
                pat_reg     <= bus.pattern_in;
                overlap_reg <= bus.overlap_in;
                z_q         <= 1'b0;
            end else begin
                z_q <= match;
            end

            // A clear coinciding with a match restarts at one so the match is kept.
            if (match) begin
                if (bus.cnt_clr)
                    cnt_q <= CNT_W'(1);
                else if (cnt_q != CNT_MAX)
                    cnt_q <= cnt_q + 1'b1;
            end else if (bus.cnt_clr) begin
                cnt_q <= '0;
            end
        end
    end

    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_q;
    assign bus.fill      = fill;

endmodule

// File: tb/tb_seqdet_param.sv
// Directed-vector bench for seqdet_param: default instance plus a 2-bit-counter instance.
module tb_seqdet_param;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seqdet_param_if #(.PAT_W(4), .CNT_W(8)) ia ();
    seqdet_param_if #(.PAT_W(4), .CNT_W(2)) ib ();

    seqdet_param #(.PAT_W(4), .PAT_RST(4'b1010), .CNT_W(8)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    seqdet_param #(.PAT_W(4), .PAT_RST(4'b1010), .CNT_W(2)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    task automatic step_a(input logic xb, input logic v);
        ia.x = xb; ia.in_valid = v;
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ia.cfg_load = 1'b0; ia.cnt_clr = 1'b0;
    endtask

    task automatic step_b(input logic xb, input logic v, input logic clr);
        ib.x = xb; ib.in_valid = v; ib.cnt_clr = clr;
        @(posedge clk); #1;
        ib.in_valid = 1'b0; ib.cnt_clr = 1'b0;
    endtask

    task automatic load_a(input logic [3:0] pat, input logic ov);
        ia.pattern_in = pat; ia.overlap_in = ov; ia.cfg_load = 1'b1;
        step_a(1'b1, 1'b1);
        checks++;
        if (ia.fill !== 3'd0 || ia.z !== 1'b0) begin
            errors++;
            $display("FAIL load_clear fill=%0d z=%0d required fill=0 z=0", ia.fill, ia.z);
        end
    endtask

    task automatic test_reset();
        ia.x = 0; ia.in_valid = 0; ia.cfg_load = 0; ia.pattern_in = '0; ia.overlap_in = 0; ia.cnt_clr = 0;
        ib.x = 0; ib.in_valid = 0; ib.cfg_load = 0; ib.pattern_in = '0; ib.overlap_in = 0; ib.cnt_clr = 0;
        #12;
        checks++;
        if (ia.z !== 1'b0 || ia.fill !== 3'd0 || ia.match_cnt !== 8'd0 || ib.match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset z=%0d fill=%0d cnt_a=%0d cnt_b=%0d required all 0",
                     ia.z, ia.fill, ia.match_cnt, ib.match_cnt);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1010;
        logic [3:0] zexp = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step_a(bits[3-i], 1'b1);
            checks++;
            if (ia.z !== zexp[3-i] || ia.fill !== 3'(i + 1)) begin
                errors++;
                $display("FAIL basic bit%0d z=%0d fill=%0d required z=%0d fill=%0d",
                         i, ia.z, ia.fill, zexp[3-i], i + 1);
            end
        end
        checks++;
        if (ia.match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL basic_cnt got %0d required 1", ia.match_cnt);
        end
        step_a(1'b0, 1'b0);
        checks++;
        if (ia.z !== 1'b0 || ia.fill !== 3'd4) begin
            errors++;
            $display("FAIL basic_pulse z=%0d fill=%0d required z=0 fill=4", ia.z, ia.fill);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits  = 7'b1010101;
        logic [6:0] zov   = 7'b0001010;
        logic [6:0] znov  = 7'b0001000;
        logic [2:0] fnov [7] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
        load_a(4'b1010, 1'b1);
        checks++;
        if (ia.match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL load_keeps_cnt got %0d required 1", ia.match_cnt);
        end
        for (int i = 0; i < 7; i++) begin
            step_a(bits[6-i], 1'b1);
            checks++;
            if (ia.z !== zov[6-i]) begin
                errors++;
                $display("FAIL overlap bit%0d z=%0d required %0d", i, ia.z, zov[6-i]);
            end
        end
        checks++;
        if (ia.match_cnt !== 8'd3) begin
            errors++;
            $display("FAIL overlap_cnt got %0d required 3", ia.match_cnt);
        end
        load_a(4'b1010, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step_a(bits[6-i], 1'b1);
            checks++;
            if (ia.z !== znov[6-i] || ia.fill !== fnov[i]) begin
                errors++;
                $display("FAIL nonoverlap bit%0d z=%0d fill=%0d required z=%0d fill=%0d",
                         i, ia.z, ia.fill, znov[6-i], fnov[i]);
            end
        end
        checks++;
        if (ia.match_cnt !== 8'd4) begin
            errors++;
            $display("FAIL nonoverlap_cnt got %0d required 4", ia.match_cnt);
        end
    endtask

    task automatic test_idle();
        logic [3:0] bits = 4'b1010;
        logic [3:0] zexp = 4'b0001;
        load_a(4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step_a(bits[3-i], 1'b1);
            checks++;
            if (ia.z !== zexp[3-i] || ia.fill !== 3'(i + 1)) begin
                errors++;
                $display("FAIL idle_valid bit%0d z=%0d fill=%0d required z=%0d fill=%0d",
                         i, ia.z, ia.fill, zexp[3-i], i + 1);
            end
            step_a(~bits[3-i], 1'b0);
            checks++;
            if (ia.z !== 1'b0 || ia.fill !== 3'(i + 1)) begin
                errors++;
                $display("FAIL idle_hold bit%0d z=%0d fill=%0d required z=0 fill=%0d",
                         i, ia.z, ia.fill, i + 1);
            end
        end
        checks++;
        if (ia.match_cnt !== 8'd5) begin
            errors++;
            $display("FAIL idle_cnt got %0d required 5", ia.match_cnt);
        end
    endtask

    task automatic test_reload();
        logic [2:0] pre  = 3'b101;
        logic [7:0] bits = 8'b0110_1010;
        logic [7:0] zexp = 8'b0001_0000;
        load_a(4'b1010, 1'b1);
        for (int i = 0; i < 3; i++) step_a(pre[2-i], 1'b1);
        load_a(4'b0110, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step_a(bits[7-i], 1'b1);
            checks++;
            if (ia.z !== zexp[7-i]) begin
                errors++;
                $display("FAIL reload bit%0d z=%0d required %0d", i, ia.z, zexp[7-i]);
            end
        end
        checks++;
        if (ia.match_cnt !== 8'd6) begin
            errors++;
            $display("FAIL reload_cnt got %0d required 6", ia.match_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] cexp [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2,
                                   2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 12; i++) begin
            step_b(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b0);
            checks++;
            if (ib.match_cnt !== cexp[i]) begin
                errors++;
                $display("FAIL saturate bit%0d cnt=%0d required %0d", i, ib.match_cnt, cexp[i]);
            end
        end
        step_b(1'b1, 1'b1, 1'b0);
        step_b(1'b0, 1'b1, 1'b1);
        checks++;
        if (ib.match_cnt !== 2'd1 || ib.z !== 1'b1) begin
            errors++;
            $display("FAIL clr_on_match cnt=%0d z=%0d required cnt=1 z=1", ib.match_cnt, ib.z);
        end
        step_b(1'b0, 1'b0, 1'b1);
        checks++;
        if (ib.match_cnt !== 2'd0 || ib.z !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone cnt=%0d z=%0d required cnt=0 z=0", ib.match_cnt, ib.z);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] bits = 7'b0110101;
        logic [5:0] post = 6'b101010;
        logic [5:0] zexp = 6'b000101;
        for (int i = 0; i < 7; i++) step_a(bits[6-i], 1'b1);
        checks++;
        if (ia.match_cnt !== 8'd7 || ia.fill !== 3'd4) begin
            errors++;
            $display("FAIL pre_reset cnt=%0d fill=%0d required cnt=7 fill=4", ia.match_cnt, ia.fill);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ia.z !== 1'b0 || ia.fill !== 3'd0 || ia.match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset z=%0d fill=%0d cnt=%0d required all 0",
                     ia.z, ia.fill, ia.match_cnt);
        end
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_a(post[5-i], 1'b1);
            checks++;
            if (ia.z !== zexp[5-i]) begin
                errors++;
                $display("FAIL post_reset bit%0d z=%0d required %0d", i, ia.z, zexp[5-i]);
            end
        end
        checks++;
        if (ia.match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL post_reset_cnt got %0d required 2", ia.match_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_idle();
        test_reload();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
